bit_deserializer: RTL and testbench

BIT_DESERIALIZER -- requirements
Module: bit_deserializer

---
 rtl/bit_deserializer.sv | 90 +++++++++
 tb/tb_bit_deserializer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_deserializer.sv
// Serial-to-parallel receiver: start bit (0), DATA_W data bits LSB first, stop bit (1),
// sampled on en strobes, with a single-entry valid/ready output register.
module bit_deserializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              d,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              overrun,
  output logic [1:0]        dbg_state
);

  // Output handshake: a word transfers on any rising edge where valid=1 and ready=1;
  // data is held stable while valid=1, and ready has no effect while valid=0.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  shreg;
  logic               last_bit;
  logic               stop_good;
  logic               stop_bad;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    if (en) begin
      case (state)
        IDLE:    if (!d) state_nx = DATA;
        DATA:    if (last_bit) state_nx = STOP;
        STOP: begin
          state_nx  = IDLE;
          stop_good = d;
          stop_bad  = !d;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (en && state == IDLE && !d) begin
        bit_cnt <= '0;
      end else if (en && state == DATA) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {d, shreg[DATA_W-1:1]};
      end
      // A completed word may replace the pending one only when it is consumed on this same edge.
      if (stop_good && (!valid || ready)) begin
        data  <= shreg;
        valid <= 1'b1;
      end else begin
        if (stop_good)      overrun <= 1'b1;
        if (valid && ready) valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed and randomized bench for bit_deserializer, checked every cycle against
// a frame-level reference model plus a scoreboard of delivered words.
module tb_bit_deserializer;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              d;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              frame_err;
  logic              overrun;
  logic [1:0]        dbg_state;

  bit_deserializer #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .d         (d),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bits seen since the start bit (-1 = waiting for start), word built arithmetically
  int                m_phase;
  int                m_word;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ferr;
  logic              m_ovr;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_phase = -1;
    m_word  = 0;
    m_data  = '0;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic deliver;
    logic ferr_n;
    logic hs;
    deliver = 1'b0;
    ferr_n  = 1'b0;
    if (reset) begin
      model_clear();
      return;
    end
    hs = m_valid && ready;
    if (en) begin
      if (m_phase < 0) begin
        if (!d) begin
          m_phase = 0;
          m_word  = 0;
        end
      end else if (m_phase < DATA_W) begin
        m_word  = m_word + (int'(d) << m_phase);
        m_phase = m_phase + 1;
      end else begin
        if (d) deliver = 1'b1;
        else   ferr_n  = 1'b1;
        m_phase = -1;
      end
    end
    if (deliver && (!m_valid || ready)) begin
      m_data  = m_word[DATA_W-1:0];
      m_valid = 1'b1;
      exp_q.push_back(m_word[DATA_W-1:0]);
    end else if (deliver) begin
      m_ovr = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
    m_ferr = ferr_n;
  endtask

  task automatic check_outputs();
    chk("valid",     32'(valid),     32'(m_valid));
    chk("data",      32'(data),      32'(m_data));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
    chk("overrun",   32'(overrun),   32'(m_ovr));
  endtask

  task automatic step();
    logic              hs_obs;
    logic [DATA_W-1:0] w_obs;
    logic [DATA_W-1:0] w_exp;
    hs_obs = (valid === 1'b1) && (ready === 1'b1) && (reset === 1'b0);
    w_obs  = data;
    @(posedge clk);
    model_edge();
    #1;
    if (hs_obs) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected observed=%0h expected=none", w_obs);
      end
      if (exp_q.size() > 0) begin
        w_exp = exp_q.pop_front();
        chk("sb_word", 32'(w_obs), 32'(w_exp));
      end
    end
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_valid",     32'(valid),     32'd0);
    chk("rst_data",      32'(data),      32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun",   32'(overrun),   32'd0);
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic strobe(input logic b);
    d  = b;
    en = 1'b1;
    step();
    en = 1'b0;
    d  = 1'b1;
    step();
  endtask

  task automatic send_bits(input logic [DATA_W-1:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) strobe(w[i]);
  endtask

  task automatic stop_edge(input logic b);
    d  = b;
    en = 1'b1;
    step();
    en = 1'b0;
    d  = 1'b1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] w);
    strobe(1'b0);
    send_bits(w, 0, DATA_W - 1);
    stop_edge(1'b1);
    step();
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    d     = 1'b1;
    ready = 1'b0;
    do_reset(2);

    // Basic frame with ready held high: valid for exactly one cycle
    ready = 1'b1;
    strobe(1'b0);
    send_bits(8'h4A, 0, 7);
    stop_edge(1'b1);
    chk("f4a_valid", 32'(valid), 32'd1);
    chk("f4a_data",  32'(data),  32'h4A);
    chk("f4a_ferr",  32'(frame_err), 32'd0);
    chk("f4a_ovr",   32'(overrun), 32'd0);
    step();
    chk("f4a_valid_drop", 32'(valid), 32'd0);

    // Second word arrives while first is pending
    ready = 1'b0;
    send_frame(8'hA5);
    chk("a5_data", 32'(data), 32'hA5);
    send_frame(8'h3C);
    chk("ovr_data",  32'(data),    32'hA5);
    chk("ovr_valid", 32'(valid),   32'd1);
    chk("ovr_flag",  32'(overrun), 32'd1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("ovr_valid_clr", 32'(valid),   32'd0);
    chk("ovr_sticky",    32'(overrun), 32'd1);

    // Bad stop bit, then a good frame
    strobe(1'b0);
    send_bits(8'hFF, 0, 7);
    stop_edge(1'b0);
    chk("ferr_pulse", 32'(frame_err), 32'd1);
    chk("ferr_valid", 32'(valid),     32'd0);
    chk("ferr_data",  32'(data),      32'hA5);
    step();
    chk("ferr_end", 32'(frame_err), 32'd0);
    ready = 1'b1;
    strobe(1'b0);
    send_bits(8'h01, 0, 7);
    stop_edge(1'b1);
    chk("f01_data",  32'(data),  32'h01);
    chk("f01_valid", 32'(valid), 32'd1);
    step();

    // Reset in the middle of a frame
    strobe(1'b0);
    send_bits(8'hC3, 0, 3);
    do_reset(2);
    send_frame(8'h5A);
    chk("f5a_data", 32'(data), 32'h5A);

    // Long en gap mid-frame; stop edge coincides with a handshake
    ready = 1'b0;
    send_frame(8'h33);
    strobe(1'b0);
    send_bits(8'h81, 0, 3);
    repeat (20) step();
    send_bits(8'h81, 4, 7);
    ready = 1'b1;
    stop_edge(1'b1);
    chk("f81_data",  32'(data),    32'h81);
    chk("f81_valid", 32'(valid),   32'd1);
    chk("f81_ovr",   32'(overrun), 32'd0);
    step();
    chk("f81_valid_clr", 32'(valid), 32'd0);

    // Idle line with strobes running
    ready = 1'b0;
    d     = 1'b1;
    repeat (25) begin
      en = 1'b1;
      step();
      en = 1'b0;
      step();
    end
    chk("idle_valid", 32'(valid),     32'd0);
    chk("idle_ferr",  32'(frame_err), 32'd0);
    chk("idle_ovr",   32'(overrun),   32'd0);

    // Random traffic, including occasional asynchronous resets
    repeat (800) begin
      en    = 1'($urandom_range(0, 1));
      d     = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) do_reset(1);
      else                            step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
